// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM for the multicycle MIPS datapath
module mips_multicycle_control #(
  parameter int STATE_W = 4,
  parameter int RA_REG = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtZero,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [5:0]         ALUFunct,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_JR = 6'h08, F_ADDU = 6'h21, F_SUB = 6'h22;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R,
    R_WB, BRANCH, JUMP, EXEC_I, I_WB, JAL, JR, BAD
  } state_t;
  state_t st, nx, dec_nx;
  logic logic_imm;
  if (RA_REG < 0 || RA_REG > 31 || STATE_W < 4) begin : g_bad_param
    $error("mips_multicycle_control: RA_REG must be 0..31 and STATE_W at least 4");
  end
  assign logic_imm = Opcode == OP_LUI || Opcode == OP_ORI;
  always_comb begin
    case (Opcode)
      OP_LW, OP_SW:                      dec_nx = MEM_ADDR;
      OP_R:                              dec_nx = (Funct == F_ADDU || Funct == F_SUB) ? EXEC_R :
                                                  (Funct == F_JR) ? JR : FETCH;
      OP_BEQ:                            dec_nx = BRANCH;
      OP_J:                              dec_nx = JUMP;
      OP_JAL:                            dec_nx = JAL;
      OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI: dec_nx = EXEC_I;
      default:                           dec_nx = FETCH;
    endcase
  end
  always_comb begin
    case (st)
      IDLE:      nx = FETCH;
      FETCH:     nx = mem_ready ? DECODE : FETCH;
      DECODE:    nx = dec_nx;
      MEM_ADDR:  nx = (Opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  nx = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: nx = mem_ready ? FETCH : MEM_WRITE;
      EXEC_R:    nx = R_WB;
      EXEC_I:    nx = I_WB;
      default:   nx = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nx;
  always_comb begin
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst = 2'b00;
    MemtoReg = 2'b00;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ExtZero = 1'b0;
    PCSource = 2'b00;
    ALUOp = 2'b00;
    ALUFunct = 6'b0;
    illegal = 1'b0;
    case (st)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        illegal = dec_nx == FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        ALUFunct = Funct;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst = 2'b01;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp = logic_imm ? 2'b11 : 2'b00;
        ALUFunct = logic_imm ? Opcode : 6'b0;
        ExtZero = logic_imm;
      end
      I_WB: RegWrite = 1'b1;
      JAL: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst = 2'b10;
        MemtoReg = 2'b10;
      end
      JR: begin
        PCWrite = 1'b1;
        PCSource = 2'b11;
      end
      default: ;
    endcase
  end
  assign state = STATE_W'(st);
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: random instruction stream checked against a per-instruction step-list model
module tb_mips_multicycle_control;
  logic clk = 1'b0, rst_n, mem_ready;
  logic [5:0] Opcode, Funct, ALUFunct;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ExtZero, illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp;
  logic [3:0] state;
  int n_tests = 0, n_fail = 0;
  int seq[$];
  int pos;

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, rw;
    logic [1:0] rd, m2r;
    logic sa;
    logic [1:0] sb;
    logic ez;
    logic [1:0] ps, aop;
    logic [5:0] af;
    logic ill;
    logic [3:0] st;
  } exp_t;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtZero(ExtZero),
    .PCSource(PCSource), .ALUOp(ALUOp), .ALUFunct(ALUFunct), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observed();
    exp_t o;
    o = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
          ALUSrcA, ALUSrcB, ExtZero, PCSource, ALUOp, ALUFunct, illegal, state};
    return 32'(o);
  endfunction

  function automatic bit legal(logic [5:0] opc, logic [5:0] fn);
    if (opc == 6'h00) return fn == 6'h21 || fn == 6'h22 || fn == 6'h08;
    return opc inside {6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h08, 6'h09, 6'h0f, 6'h0d};
  endfunction

  // Step list an instruction walks through, starting with fetch and decode
  function automatic void plan(logic [5:0] opc, logic [5:0] fn);
    if (!legal(opc, fn)) seq = '{1, 2};
    else if (opc == 6'h23) seq = '{1, 2, 3, 4, 5};
    else if (opc == 6'h2b) seq = '{1, 2, 3, 6};
    else if (opc == 6'h00) begin
      if (fn == 6'h08) seq = '{1, 2, 14};
      else seq = '{1, 2, 7, 8};
    end
    else if (opc == 6'h04) seq = '{1, 2, 9};
    else if (opc == 6'h02) seq = '{1, 2, 10};
    else if (opc == 6'h03) seq = '{1, 2, 13};
    else seq = '{1, 2, 11, 12};
  endfunction

  function automatic logic [31:0] expected(int s, logic [5:0] opc, logic [5:0] fn, logic rdy);
    exp_t e;
    e = '0;
    e.st = 4'(s);
    case (s)
      1: begin e.mrd = 1; e.sb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      2: begin e.sb = 2'b11; e.ill = !legal(opc, fn); end
      3: begin e.sa = 1; e.sb = 2'b10; end
      4: begin e.mrd = 1; e.iord = 1; end
      5: begin e.rw = 1; e.m2r = 2'b01; end
      6: begin e.mwr = 1; e.iord = 1; end
      7: begin e.sa = 1; e.aop = 2'b10; e.af = fn; end
      8: begin e.rw = 1; e.rd = 2'b01; end
      9: begin e.sa = 1; e.aop = 2'b01; e.pcwc = 1; e.ps = 2'b01; end
      10: begin e.pcw = 1; e.ps = 2'b10; end
      11: begin
        e.sa = 1; e.sb = 2'b10;
        if (opc == 6'h0f || opc == 6'h0d) begin e.aop = 2'b11; e.af = opc; e.ez = 1; end
      end
      12: e.rw = 1;
      13: begin e.pcw = 1; e.ps = 2'b10; e.rw = 1; e.rd = 2'b10; e.m2r = 2'b10; end
      14: begin e.pcw = 1; e.ps = 2'b11; end
      default: ;
    endcase
    return 32'(e);
  endfunction

  task automatic pick();
    logic [5:0] ops [10] = '{6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h08, 6'h09, 6'h0f, 6'h0d, 6'h00};
    logic [5:0] rfn [3] = '{6'h21, 6'h22, 6'h08};
    int k;
    k = $urandom_range(0, 12);
    if (k < 10) begin
      Opcode = ops[k];
      Funct = (k == 9) ? rfn[$urandom_range(0, 2)] : 6'($urandom);
    end else begin
      Opcode = (k == 10) ? 6'h00 : 6'($urandom);
      Funct = 6'($urandom);
    end
    plan(Opcode, Funct);
  endtask

  initial begin
    bit hit;
    logic rdy;
    rst_n = 1'b0; mem_ready = 1'b1; Opcode = 6'h2b; Funct = 6'h00;
    #1 check("reset", observed(), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = state == 4'd3;
    end
    check("reach_mem_addr", 32'(state), 32'd3);
    mem_ready = 1'b0;
    @(negedge clk) #1 check("mem_write", observed(), expected(6, Opcode, Funct, 1'b0));
    #2 rst_n = 1'b0;
    #1 check("async_reset", observed(), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("release_idle", observed(), 32'h0);
    @(posedge clk) #1 check("first_fetch", observed(), expected(1, Opcode, Funct, mem_ready));
    pos = 0;
    plan(Opcode, Funct);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (pos == 0) pick();
      rdy = $urandom_range(0, 2) != 0;
      mem_ready = rdy;
      #1 check($sformatf("cyc%0d step%0d op%h fn%h", c, seq[pos], Opcode, Funct),
               observed(), expected(seq[pos], Opcode, Funct, rdy));
      if (!(seq[pos] inside {1, 4, 6}) || rdy) pos++;
      if (pos == seq.size()) pos = 0;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
